// File: rtl/muldiv_unit.sv
// ============================================================================
// Module   : muldiv_unit
// Brief    : Iterative MULT/MULTU/DIV/DIVU unit owning the HI/LO registers.
// Revision : 1.0
// ============================================================================
`default_nettype none

module muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             wr_hi,
  input  logic             wr_lo,
  input  logic [WIDTH-1:0] wr_data,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy,
  output logic             done
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [1:0]       c_st_idle = 2'd0;
  localparam logic [1:0]       c_st_calc = 2'd1;
  localparam logic [1:0]       c_st_fix  = 2'd2;
  localparam logic [CNT_W-1:0] c_last    = CNT_W'(WIDTH - 1);

  logic [1:0]         r_state;
  logic [1:0]         w_state_nxt;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_is_div;
  logic               r_neg_lo;
  logic               r_neg_hi;
  logic               r_dz;
  logic [WIDTH-1:0]   r_a_orig;
  logic [WIDTH-1:0]   r_opnd;
  logic [2*WIDTH-1:0] r_acc;
  logic [WIDTH-1:0]   r_hi;
  logic [WIDTH-1:0]   r_lo;
  logic               r_busy;
  logic               r_done;

  logic               w_launch;
  logic               w_host_wr;
  logic               w_busy_nxt;
  logic               w_done_nxt;

  // Operand magnitudes and sign flags at launch
  logic               w_a_neg;
  logic               w_b_neg;
  logic [WIDTH-1:0]   w_a_mag;
  logic [WIDTH-1:0]   w_b_mag;

  assign w_a_neg = ~op[0] & a[WIDTH-1];
  assign w_b_neg = ~op[0] & b[WIDTH-1];
  assign w_a_mag = w_a_neg ? (~a + 1'b1) : a;
  assign w_b_mag = w_b_neg ? (~b + 1'b1) : b;

  // Shift-add: multiplier sits in the low half of the accumulator, consumed LSB first
  logic [WIDTH:0]     w_add;
  logic [2*WIDTH-1:0] w_mul_nxt;

  assign w_add     = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + (r_acc[0] ? {1'b0, r_opnd} : '0);
  assign w_mul_nxt = {w_add, r_acc[WIDTH-1:1]};

  // Restoring divide: {remainder, dividend/quotient} shifts left one bit per step
  logic [WIDTH:0]     w_rem_sh;
  logic               w_ge;
  logic [WIDTH-1:0]   w_sub;
  logic [2*WIDTH-1:0] w_div_nxt;

  assign w_rem_sh  = r_acc[2*WIDTH-1:WIDTH-1];
  assign w_ge      = (w_rem_sh >= {1'b0, r_opnd});
  assign w_sub     = w_rem_sh[WIDTH-1:0] - r_opnd;
  assign w_div_nxt = {(w_ge ? w_sub : w_rem_sh[WIDTH-1:0]), r_acc[WIDTH-2:0], w_ge};

  logic [2*WIDTH-1:0] w_prod;
  logic [WIDTH-1:0]   w_quo;
  logic [WIDTH-1:0]   w_rem;
  logic [WIDTH-1:0]   w_fix_hi;
  logic [WIDTH-1:0]   w_fix_lo;

  assign w_prod = r_neg_lo ? (~r_acc + 1'b1) : r_acc;
  assign w_quo  = r_neg_lo ? (~r_acc[WIDTH-1:0] + 1'b1) : r_acc[WIDTH-1:0];
  assign w_rem  = r_neg_hi ? (~r_acc[2*WIDTH-1:WIDTH] + 1'b1) : r_acc[2*WIDTH-1:WIDTH];

  always_comb begin
    w_fix_hi = w_prod[2*WIDTH-1:WIDTH];
    w_fix_lo = w_prod[WIDTH-1:0];
    if (r_is_div) begin
      // Divide by zero returns the untouched dividend and an all-ones quotient
      w_fix_hi = r_dz ? r_a_orig : w_rem;
      w_fix_lo = r_dz ? '1 : w_quo;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= c_st_idle;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      c_st_idle: if (start) w_state_nxt = c_st_calc;
      c_st_calc: if (r_cnt == c_last) w_state_nxt = c_st_fix;
      c_st_fix:  w_state_nxt = c_st_idle;
      default:   w_state_nxt = c_st_idle;
    endcase
  end

  always_comb begin
    w_launch   = (r_state == c_st_idle) & start;
    w_host_wr  = (r_state == c_st_idle);
    w_busy_nxt = (w_state_nxt == c_st_calc) | (w_state_nxt == c_st_fix);
    w_done_nxt = (r_state == c_st_fix);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cnt    <= '0;
      r_is_div <= 1'b0;
      r_neg_lo <= 1'b0;
      r_neg_hi <= 1'b0;
      r_dz     <= 1'b0;
      r_a_orig <= '0;
      r_opnd   <= '0;
      r_acc    <= '0;
      r_hi     <= '0;
      r_lo     <= '0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_busy <= w_busy_nxt;
      r_done <= w_done_nxt;
      if (w_launch) begin
        r_cnt    <= '0;
        r_is_div <= op[1];
        r_neg_lo <= w_a_neg ^ w_b_neg;
        r_neg_hi <= w_a_neg & op[1];
        r_dz     <= op[1] & (b == '0);
        r_a_orig <= a;
        r_opnd   <= op[1] ? w_b_mag : w_a_mag;
        r_acc    <= {{WIDTH{1'b0}}, (op[1] ? w_a_mag : w_b_mag)};
      end else if (r_state == c_st_calc) begin
        r_cnt <= r_cnt + 1'b1;
        r_acc <= r_is_div ? w_div_nxt : w_mul_nxt;
      end
      if (r_state == c_st_fix) begin
        r_hi <= w_fix_hi;
        r_lo <= w_fix_lo;
      end else if (w_host_wr) begin
        if (wr_hi) r_hi <= wr_data;
        if (wr_lo) r_lo <= wr_data;
      end
    end
  end

  assign hi   = r_hi;
  assign lo   = r_lo;
  assign busy = r_busy;
  assign done = r_done;

endmodule

`default_nettype wire

// File: doc/muldiv_unit.md
# muldiv_unit

Iterative multiply/divide unit serving MULT, MULTU, DIV, DIVU, MFHI/MFLO and MTHI/MTLO in the MIPS datapath. It sits downstream of the register file, beside the ALU, and takes the two register operands (rs, rt) as its inputs. The unit produces the architectural HI/LO registers over a fixed multi-cycle latency and raises `busy` so the control path can stall the PC while a result is pending.

## Interface
- WIDTH, 32: operand and HI/LO width; the iteration count equals WIDTH.
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-low reset
- start  input  1  launch an operation; sampled only in IDLE
- op  input  2  00=MULT, 01=MULTU, 10=DIV, 11=DIVU
- a  input  WIDTH  rs operand (multiplicand / dividend)
- b  input  WIDTH  rt operand (multiplier / divisor)
- wr_hi  input  1  MTHI write strobe
- wr_lo  input  1  MTLO write strobe
- wr_data  input  WIDTH  MTHI/MTLO data
- hi  output  WIDTH  HI register (product[63:32] / remainder)
- lo  output  WIDTH  LO register (product[31:0] / quotient)
- busy  output  1  operation in flight; the PC must stall
- done  output  1  one-cycle pulse when HI/LO take a new result

## Operation
- States:
  - IDLE: waits for `start`, then captures operands and goes to CALC.
  - CALC: runs WIDTH iterations counted by a 5-bit counter, then goes to FIX.
  - FIX: applies sign correction, writes HI/LO, pulses `done`, then returns to IDLE.
- Operand capture in IDLE on `start`:
  - Latch `op` and the operand magnitudes. Signed ops (MULT, DIV) use |a| and |b|.
  - Latch the result sign. For MULT and the DIV quotient it is a[31]^b[31]. For the DIV remainder it is a[31].
- MULT/MULTU: shift-add, one multiplier bit per cycle, into a 2×WIDTH accumulator. In FIX, if the sign flag is set, the 64-bit result is negated.
- DIV/DIVU: restoring division, one quotient bit per cycle.
  - In FIX, negate the quotient if the quotient sign is set.
  - In FIX, negate the remainder if the remainder sign is set.
  - The remainder always takes the dividend's sign.
- Divide by zero (b==0), with latency unchanged:
  - LO = all ones.
  - HI = a (the original, unmodified dividend).
  - Applies to both DIV and DIVU.
- Signed overflow, DIV 0x80000000 / 0xFFFFFFFF: LO = 0x80000000, HI = 0 (natural wrap, no trap).
- MTHI/MTLO:
  - In IDLE, `wr_hi` / `wr_lo` update `hi` / `lo` at the clock edge.
  - While busy, both strobes are ignored.
  - If `start` and a write arrive in the same IDLE cycle, both are accepted. The write is visible immediately and is later overwritten by the result.
- `start` while busy is ignored, with no queuing.
- `hi` and `lo` hold their values at all times except during a write or in FIX. MFHI/MFLO reads during busy return the old value; the control path must stall those reads.

## Timing
- Reset (asynchronous, active-low):
  - State = IDLE; hi = 0, lo = 0, busy = 0, done = 0; the counter is cleared.
  - Applies immediately, including mid-operation. The in-flight operation is discarded and no `done` pulse is produced.
- Latency: call the start edge E0.
  - `busy` is high from after E0 through after E32.
  - CALC occupies edges E1..E32. FIX occurs at edge E33.
  - `hi` and `lo` update at E33. `done` is high for the one cycle after E33, and `busy` is low in that same cycle.
  - Total: 33 cycles from start to result.
- Back-to-back: a new `start` is accepted in the cycle where `done` is high. Throughput is one operation per 34 cycles.
- `busy` is a registered output, glitch-free. `done` is registered and high for exactly one cycle per completed operation.
- Operands `a`, `b`, `op` are needed only in the start cycle; they are don't-care afterwards.

## Test plan
- MULT a=0xFFFFFFFD (−3), b=5 → after 33 cycles: hi=0xFFFFFFFF, lo=0xFFFFFFF1, done pulses once, busy high for exactly 33 cycles.
- MULTU a=b=0xFFFFFFFF → hi=0xFFFFFFFE, lo=0x00000001. Then issue MULT with the same operands → hi=0, lo=1.
- DIV a=0xFFFFFFF9 (−7), b=2 → lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIVU a=7, b=2 → lo=3, hi=1.
- DIVU a=0x1234, b=0 → lo=0xFFFFFFFF, hi=0x1234. DIV a=0x80000000, b=0xFFFFFFFF → lo=0x80000000, hi=0.
- MTHI 0xA5A5A5A5 in IDLE → hi updates next edge. Start MULTU 2×3, then pulse wr_lo=0xDEAD and a second start while busy → both ignored; final hi=0, lo=6, exactly one done pulse.
- Start DIV, assert reset low asynchronously at cycle 10 → hi=lo=0 and busy=0 immediately, no done pulse. After release, a new MULTU 4×4 → lo=16.
